// File: rtl/vec_pkg.sv
// vec_pkg: shared vector-memory widths, legal VRF window and sequencer state type
package vec_pkg;
  localparam int VEC_W = 256;
  localparam int WORD_W = 32;
  localparam int LANES = 8;
  localparam logic [4:0] VREG_FIRST = 5'd16;
  localparam logic [4:0] VREG_LAST = 5'd23;
  typedef enum logic [2:0] {IDLE, LOAD, WB, STORE, FIN} state_t;
endpackage

// File: rtl/vec_lane_buffer.sv
// vec_lane_buffer: lane-indexed write buffer (clk, rst, clr wipes all lanes, we/idx/wd writes one lane, q is the full vector)
module vec_lane_buffer #(
  parameter int WORD_W = 32,
  parameter int LANES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      we,
  input  logic [$clog2(LANES)-1:0]  idx,
  input  logic [WORD_W-1:0]         wd,
  output logic [WORD_W*LANES-1:0]   q
);
  logic [WORD_W*LANES-1:0] q_q, q_d;
  always_comb begin
    q_d = clr ? '0 : q_q;
    if (we) q_d[idx*WORD_W +: WORD_W] = wd;
  end
  always_ff @(posedge clk) q_q <= rst ? '0 : q_d;
  assign q = q_q;
endmodule

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: moves one vector register to/from memory in 8 word beats (start/op/vreg/base_addr in; busy/done/err status; mem_* data port; vra/vrd VRF read; vwe/vwa/vwd VRF write)
module vec_mem_sequencer #(
  parameter int WORD_W = 32,
  parameter int LANES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     op,
  input  logic [4:0]               vreg,
  input  logic [WORD_W-1:0]        base_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [WORD_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic [WORD_W-1:0]        mem_wd,
  input  logic [WORD_W-1:0]        mem_rd,
  output logic [4:0]               vra,
  input  logic [WORD_W*LANES-1:0]  vrd,
  output logic                     vwe,
  output logic [4:0]               vwa,
  output logic [WORD_W*LANES-1:0]  vwd
);
  import vec_pkg::*;
  localparam int CW = $clog2(LANES);
  state_t state_q, state_d;
  logic op_q, op_d, bad_q, bad_d, take, last, act;
  logic [4:0] vreg_q, vreg_d;
  logic [WORD_W-1:0] base_q, base_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WORD_W*LANES-1:0] buf_q;
  assign take = state_q == IDLE && start;
  assign last = cnt_q == CW'(LANES - 1);
  assign act = state_q == LOAD || state_q == STORE;
  always_comb begin
    op_d = take ? op : op_q;
    vreg_d = take ? vreg : vreg_q;
    base_d = take ? base_addr : base_q;
    bad_d = take ? (vreg < VREG_FIRST || vreg > VREG_LAST || base_addr[1:0] != 2'b00) : bad_q;
    cnt_d = take ? '0 : act ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      IDLE:    state_d = !start ? IDLE : bad_d ? FIN : op ? STORE : LOAD;
      LOAD:    state_d = last ? WB : LOAD;
      STORE:   state_d = last ? FIN : STORE;
      WB:      state_d = FIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= 1'b0;
      bad_q <= 1'b0;
      vreg_q <= '0;
      base_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      bad_q <= bad_d;
      vreg_q <= vreg_d;
      base_q <= base_d;
      cnt_q <= cnt_d;
    end
  end
  vec_lane_buffer #(.WORD_W(WORD_W), .LANES(LANES)) u_buf (
    .clk(clk),
    .rst(rst),
    .clr(take),
    .we(state_q == LOAD),
    .idx(cnt_q),
    .wd(mem_rd),
    .q(buf_q)
  );
  assign busy = act || state_q == WB;
  assign done = state_q == FIN;
  assign err = done && bad_q;
  assign mem_addr = act ? base_q + (WORD_W'(cnt_q) << 2) : '0;
  assign mem_we = state_q == STORE;
  assign mem_wd = mem_we ? vrd[cnt_q*WORD_W +: WORD_W] : '0;
  assign vra = vreg_q;
  assign vwe = state_q == WB;
  assign vwa = vwe ? vreg_q : '0;
  assign vwd = vwe ? buf_q : '0;
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb_vec_mem_sequencer: directed and randomized checks of the vector load/store sequencer against a cycle-count model
module tb_vec_mem_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, op = 1'b0;
  logic [4:0] vreg = '0;
  logic [31:0] base_addr = '0;
  logic busy, done, err, mem_we, vwe;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [4:0] vra, vwa;
  logic [255:0] vrd = '0, vwd;
  logic [31:0] salt = '0, dir_base = '0;
  logic dir_on = 1'b0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  vec_mem_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .vreg(vreg), .base_addr(base_addr),
    .busy(busy), .done(done), .err(err), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .vra(vra), .vrd(vrd), .vwe(vwe), .vwa(vwa), .vwd(vwd)
  );

  function automatic logic [31:0] mem_at(input logic [31:0] a, input logic d_on, input logic [31:0] d_base, input logic [31:0] s);
    logic [31:0] off;
    off = a - d_base;
    return (d_on && off < 32) ? 32'hA0 + (off >> 2) : (a * 32'h9E37_79B1) ^ s;
  endfunction

  always_comb mem_rd = mem_at(mem_addr, dir_on, dir_base, salt);

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wd"}, mem_wd, 0);
    chk({tag, "_vwe"}, vwe, 0);
    chk({tag, "_vwd"}, vwd, 0);
  endtask

  task automatic do_op(input logic o, input logic [4:0] v, input logic [31:0] b, input logic poke);
    logic bad, act, wb;
    int total;
    logic [255:0] exp_v;
    logic [31:0] a;
    bad = v < 16 || v > 23 || b[1:0] != 2'b00;
    total = bad ? 1 : o ? 9 : 10;
    for (int i = 0; i < 8; i++) exp_v[32*i +: 32] = mem_at(b + 32'(4 * i), dir_on, dir_base, salt);
    start = 1'b1; op = o; vreg = v; base_addr = b;
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); vreg = 5'($urandom); base_addr = $urandom;
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      act = !bad && c <= 8;
      wb = !bad && !o && c == 9;
      a = b + 32'(4 * (c - 1));
      chk("busy", busy, c < total);
      chk("done", done, c == total);
      chk("err", err, c == total && bad);
      chk("mem_we", mem_we, act && o);
      chk("mem_addr", mem_addr, act ? a : 32'h0);
      chk("mem_wd", mem_wd, (act && o) ? vrd[32*((c - 1) % 8) +: 32] : 32'h0);
      chk("vwe", vwe, wb);
      chk("vwd", vwd, wb ? exp_v : 256'h0);
      if (wb) chk("vwa", vwa, v);
      if (c < total) chk("vra", vra, v);
      if (poke && !bad) start = (c == 3);
    end
    start = 1'b0;
  endtask

  task automatic rst_mid(input logic o, input int cyc);
    start = 1'b1; op = o; vreg = 5'd18; base_addr = 32'h40;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= cyc; c++) @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 1'b0; vreg = 5'd20; base_addr = 32'h80;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      idle_chk("after_rst");
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] r, b;
    repeat (2) @(negedge clk);
    idle_chk("rst");
    chk("rst_vra", vra, 0);
    chk("rst_vwa", vwa, 0);
    rst = 1'b0;
    @(negedge clk);
    idle_chk("post_rst");
    dir_on = 1'b1; dir_base = 32'h100;
    do_op(1'b0, 5'd17, 32'h100, 1'b0);
    dir_on = 1'b0;
    for (int i = 0; i < 8; i++) vrd[32*i +: 32] = 32'h1111_0000 + 32'(i);
    do_op(1'b1, 5'd23, 32'h200, 1'b0);
    do_op(1'b0, 5'd5, 32'h100, 1'b0);
    do_op(1'b1, 5'd20, 32'h102, 1'b0);
    do_op(1'b0, 5'd24, 32'h0, 1'b0);
    salt = $urandom;
    do_op(1'b0, 5'd20, 32'hFFFF_FFF8, 1'b1);
    do_op(1'b1, 5'd16, 32'hFFFF_FFF8, 1'b1);
    rst_mid(1'b0, 5);
    do_op(1'b0, 5'd19, 32'h300, 1'b0);
    rst_mid(1'b1, 5);
    do_op(1'b1, 5'd21, 32'h80, 1'b0);
    repeat (40) begin
      salt = $urandom;
      for (int i = 0; i < 8; i++) vrd[32*i +: 32] = $urandom;
      r = $urandom;
      b = {r[31:2], ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00};
      do_op(1'($urandom_range(0, 1)), 5'($urandom_range(14, 25)), b, 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vec_mem_sequencer.md
VEC_MEM_SEQUENCER -- requirements
Module: vec_mem_sequencer

Interface
REQ-001 Parameter: WORD_W, 32, memory data and address width.
REQ-002 Parameter: LANES, 8, 32-bit lanes per 256-bit vector register.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset rst, synchronous, active-high.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 op  input  1  0 = vector load (mem->VRF), 1 = vector store (VRF->mem).
REQ-007 vreg  input  5  target vector register; legal range 16..23.
REQ-008 base_addr  input  32  byte address of lane 0.
REQ-009 busy  output  1  high in LOAD, WB and STORE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  one-cycle error pulse, coincident with done.
REQ-012 mem_addr  output  32  data memory byte address.
REQ-013 mem_we  output  1  data memory write enable.
REQ-014 mem_wd  output  32  data memory write data.
REQ-015 mem_rd  input  32  data memory read data, combinational from mem_addr.
REQ-016 vra  output  5  VRF read address; equals latched vreg.
REQ-017 vrd  input  256  VRF read data for vra.
REQ-018 vwe, vwa, vwd  output  1/5/256  VRF write port; VRF commits on falling edge, so vwe is held for the full cycle.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, WB, STORE, FIN.
REQ-020 In IDLE, start=1 SHALL latch op, vreg, base_addr and clear a 3-bit beat counter; start outside IDLE SHALL be ignored.
REQ-021 If latched vreg is outside 16..23 or base_addr[1:0] != 0, FSM SHALL go IDLE->FIN with no memory or VRF access; FIN then asserts done=1 and err=1.
REQ-022 Otherwise op=0 SHALL go to LOAD and op=1 to STORE.
REQ-023 Beat i (0..7) SHALL drive mem_addr = base + 4*i, modulo 2^32 (wrap permitted).
REQ-024 LOAD beat i SHALL capture mem_rd into buffer bits [32i+31:32i]; lane 0 is the LSB.
REQ-025 After beat 7, LOAD SHALL go to WB; WB drives vwe=1, vwa=vreg, vwd=buffer for exactly one cycle, then goes to FIN.
REQ-026 STORE beat i SHALL drive mem_we=1 and mem_wd=vrd[32i+31:32i]; after beat 7 it goes to FIN.
REQ-027 FIN SHALL assert done=1 (err=0 unless REQ-021 applies) and busy=0 for one cycle, then go to IDLE.
REQ-028 Latency from the start-sampling edge: load 8 beat cycles + WB + FIN (done in cycle 10); store 8 beats + FIN (done in cycle 9); error: done in cycle 1.
REQ-029 Outside their active states, mem_we, vwe, done and err SHALL be 0, and mem_addr, mem_wd, vwd SHALL be 0.
REQ-030 The beat counter SHALL wrap from 7 to 0 on the last beat.

Reset
REQ-031 rst SHALL force IDLE, clear the latched op, vreg, base and buffer, and clear the counter at the next edge; all outputs SHALL be 0.
REQ-032 rst during LOAD SHALL prevent any VRF write; rst during STORE stops mem_we from the following cycle; no done is produced.
REQ-033 rst SHALL have priority over start in the same cycle.

Structure
REQ-034 Package vec_pkg SHALL hold VEC_W=256, WORD_W=32, LANES=8, VREG_FIRST=16, VREG_LAST=23 and the state enum type.
REQ-035 One sub-module, vec_lane_buffer (256-bit lane-indexed write buffer with clear), is natural; the FSM and counter stay in the top module.

Verification
REQ-036 Load: vreg=17, base=0x100, mem[0x100+4i]=0xA0+i -> vwe pulse in cycle 9, vwa=17, vwd lane i = 0xA0+i, done in cycle 10.
REQ-037 Store: vreg=23, vrd lane i=0x1111_0000+i, base=0x200 -> 8 writes to 0x200..0x21C with matching data, done in cycle 9, vwe stays 0.
REQ-038 Error: vreg=5 and, separately, base=0x102 -> done=err=1 in cycle 1, mem_we=vwe=0 throughout.
REQ-039 Wrap and ignore: base=0xFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0, 4, ... 0x14; start pulsed while busy has no effect.
REQ-040 Reset in load beat 4 -> IDLE next cycle, no vwe, no done; a new load immediately afterwards completes normally.
